// File: rtl/nn_pkg.sv
// Shared constants and types for the MNIST inference control path.
package nn_pkg;

  localparam int unsigned N_IN  = 784;
  localparam int unsigned N_HID = 64;
  localparam int unsigned N_OUT = 10;

  localparam int unsigned W_BASE_L1 = N_IN * N_HID;
  localparam int unsigned IN_AW     = $clog2(N_IN);
  localparam int unsigned W_AW      = $clog2(N_IN * N_HID + N_HID * N_OUT);
  localparam int unsigned NEURON_AW = $clog2(N_HID);

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StDrain,
    StWb,
    StDone
  } seq_state_t;

endpackage

// File: rtl/nn_sequencer.sv
// Control FSM sequencing one two-layer inference over the shared MAC datapath.
// Issues activation/weight addresses and MAC/write-back strobes only.
module nn_sequencer #(
  parameter int unsigned N_IN    = nn_pkg::N_IN,
  parameter int unsigned N_HID   = nn_pkg::N_HID,
  parameter int unsigned N_OUT   = nn_pkg::N_OUT,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic                                         Clk,
  input  logic                                         Reset,
  input  logic                                         Start,
  output logic                                         Done,
  output logic                                         Busy,
  output logic                                         Layer,
  output logic [$clog2(N_IN)-1:0]                      In_Addr,
  output logic [$clog2(N_IN*N_HID+N_HID*N_OUT)-1:0]    W_Addr,
  output logic                                         Mac_En,
  output logic                                         Mac_Clr,
  output logic                                         Neuron_WE,
  output logic [$clog2(N_HID)-1:0]                     Neuron_Addr
);
  import nn_pkg::*;

  localparam int unsigned IAW     = $clog2(N_IN);
  localparam int unsigned WAW     = $clog2(N_IN * N_HID + N_HID * N_OUT);
  localparam int unsigned NAW     = $clog2(N_HID);
  localparam int unsigned DW      = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int unsigned L1_BASE = N_IN * N_HID;

  seq_state_t     state_q, state_d;
  logic           start_q;
  logic           layer_q, layer_d;
  logic [IAW-1:0] elem_q, elem_d;
  logic [NAW-1:0] neuron_q, neuron_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [WAW-1:0] wptr_q, wptr_d;

  logic           rise;
  logic           busy;
  logic [IAW-1:0] k_last;
  logic [NAW-1:0] m_last;

  assign rise   = Start & ~start_q;
  assign busy   = (state_q == StMac) || (state_q == StDrain) || (state_q == StWb);
  assign k_last = layer_q ? IAW'(N_HID - 1) : IAW'(N_IN - 1);
  assign m_last = layer_q ? NAW'(N_OUT - 1) : NAW'(N_HID - 1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      layer_q  <= 1'b0;
      elem_q   <= '0;
      neuron_q <= '0;
      drain_q  <= '0;
      wptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= Start;
      layer_q  <= layer_d;
      elem_q   <= elem_d;
      neuron_q <= neuron_d;
      drain_q  <= drain_d;
      wptr_q   <= wptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    elem_d   = elem_q;
    neuron_d = neuron_q;
    drain_d  = drain_q;
    wptr_d   = wptr_q;

    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StMac;
      end
      StMac: begin
        elem_d = elem_q + IAW'(1);
        wptr_d = wptr_q + WAW'(1);
        if (elem_q == k_last) begin
          elem_d  = '0;
          drain_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_q == DW'(MAC_LAT - 1)) begin
          drain_d = '0;
          state_d = StWb;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StWb: begin
        if (neuron_q != m_last) begin
          neuron_d = neuron_q + NAW'(1);
          state_d  = StMac;
        end else if (!layer_q) begin
          layer_d  = 1'b1;
          neuron_d = '0;
          wptr_d   = WAW'(L1_BASE);
          state_d  = StMac;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!Start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Dropping Start mid-run abandons the inference without a Done.
    if (busy && !Start) state_d = StIdle;

    // Every run starts from clean counters, whichever way IDLE is entered.
    if (state_d == StIdle) begin
      layer_d  = 1'b0;
      elem_d   = '0;
      neuron_d = '0;
      drain_d  = '0;
      wptr_d   = '0;
    end
  end

  always_comb begin
    Busy        = busy;
    Done        = (state_q == StDone);
    Layer       = layer_q;
    Mac_En      = (state_q == StMac);
    Mac_Clr     = Mac_En && (elem_q == '0);
    In_Addr     = Mac_En ? elem_q : '0;
    W_Addr      = Mac_En ? wptr_q : '0;
    Neuron_WE   = (state_q == StWb);
    Neuron_Addr = Neuron_WE ? neuron_q : '0;
  end

endmodule

// File: tb/tb_nn_sequencer.sv
// Scoreboard bench for nn_sequencer with a reduced 4-3-2 network.
module tb_nn_sequencer;

  localparam int unsigned N_IN    = 4;
  localparam int unsigned N_HID   = 3;
  localparam int unsigned N_OUT   = 2;
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned IAW     = $clog2(N_IN);
  localparam int unsigned WAW     = $clog2(N_IN * N_HID + N_HID * N_OUT);
  localparam int unsigned NAW     = $clog2(N_HID);

  typedef struct packed {
    logic           strict;
    logic           done;
    logic           busy;
    logic           layer;
    logic           mac_en;
    logic           mac_clr;
    logic           we;
    logic [IAW-1:0] in_addr;
    logic [WAW-1:0] w_addr;
    logic [NAW-1:0] naddr;
  } exp_t;

  logic           Clk;
  logic           Reset;
  logic           Start;
  logic           Done;
  logic           Busy;
  logic           Layer;
  logic [IAW-1:0] In_Addr;
  logic [WAW-1:0] W_Addr;
  logic           Mac_En;
  logic           Mac_Clr;
  logic           Neuron_WE;
  logic [NAW-1:0] Neuron_Addr;

  exp_t sb[$];
  int   errors;
  int   checks;

  nn_sequencer #(
    .N_IN    (N_IN),
    .N_HID   (N_HID),
    .N_OUT   (N_OUT),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Done        (Done),
    .Busy        (Busy),
    .Layer       (Layer),
    .In_Addr     (In_Addr),
    .W_Addr      (W_Addr),
    .Mac_En      (Mac_En),
    .Mac_Clr     (Mac_Clr),
    .Neuron_WE   (Neuron_WE),
    .Neuron_Addr (Neuron_Addr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Addresses only matter under their strobe; Layer only while running (or when strict).
  function automatic exp_t observe(input exp_t e);
    exp_t a;
    a.strict  = e.strict;
    a.done    = Done;
    a.busy    = Busy;
    a.layer   = (e.busy || e.strict) ? Layer : 1'b0;
    a.mac_en  = Mac_En;
    a.mac_clr = Mac_Clr;
    a.we      = Neuron_WE;
    a.in_addr = e.mac_en ? In_Addr : '0;
    a.w_addr  = e.mac_en ? W_Addr : '0;
    a.naddr   = e.we ? Neuron_Addr : '0;
    return a;
  endfunction

  // Expected per-cycle outputs for a full run, cycle 0 through cycle T.
  task automatic push_run();
    exp_t e;
    int   w;
    int   k;
    int   m;
    w = 0;
    for (int l = 0; l < 2; l++) begin
      k = (l == 0) ? N_IN : N_HID;
      m = (l == 0) ? N_HID : N_OUT;
      for (int n = 0; n < m; n++) begin
        for (int i = 0; i < k; i++) begin
          e = '0; e.busy = 1'b1; e.layer = (l == 1); e.mac_en = 1'b1;
          e.mac_clr = (i == 0); e.in_addr = IAW'(i); e.w_addr = WAW'(w);
          sb.push_back(e);
          w++;
        end
        for (int d = 0; d < MAC_LAT; d++) begin
          e = '0; e.busy = 1'b1; e.layer = (l == 1);
          sb.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.layer = (l == 1); e.we = 1'b1; e.naddr = NAW'(n);
        sb.push_back(e);
      end
    end
    e = '0; e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int n, input logic strict);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.strict = strict;
      sb.push_back(e);
    end
  endtask

  task automatic push_done(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.done = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic keep_first(input int n);
    while (sb.size() > n) void'(sb.pop_back());
  endtask

  task automatic test_reset();
    exp_t e, a;
    int   c;
    Reset = 1'b1;
    Start = 1'b0;
    @(posedge Clk); #1;
    push_idle(12, 1'b1);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 2) Reset = 1'b0;
      @(negedge Clk);
      e = sb.pop_front();
      a = observe(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", c, a, e);
      end
      @(posedge Clk); #1;
      c++;
    end
  endtask

  task automatic test_full_run();
    exp_t e, a;
    int   c;
    Start = 1'b1;
    @(posedge Clk); #1;
    push_run();
    c = 0;
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      a = observe(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL full_run cyc %0d: got %h want %h", c, a, e);
      end
      @(posedge Clk); #1;
      c++;
    end
  endtask

  // Continues straight from the end of test_full_run with Start still high.
  task automatic test_done_hold();
    exp_t e, a;
    int   c;
    int   stop_at;
    push_done(21);
    push_idle(1, 1'b0);
    push_run();
    stop_at = sb.size();
    push_done(1);
    push_idle(2, 1'b0);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 20) Start = 1'b0;
      if (c == 21) Start = 1'b1;
      if (c == stop_at) Start = 1'b0;
      @(negedge Clk);
      e = sb.pop_front();
      a = observe(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL done_hold idx %0d: got %h want %h", c, a, e);
      end
      @(posedge Clk); #1;
      c++;
    end
  endtask

  task automatic test_abort();
    exp_t e, a;
    int   c;
    Start = 1'b1;
    @(posedge Clk); #1;
    push_run();
    keep_first(11);
    push_idle(12, 1'b0);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 10) Start = 1'b0;
      @(negedge Clk);
      e = sb.pop_front();
      a = observe(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL abort cyc %0d: got %h want %h", c, a, e);
      end
      @(posedge Clk); #1;
      c++;
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e, a;
    int   c;
    int   stop_at;
    Start = 1'b1;
    @(posedge Clk); #1;
    push_run();
    keep_first(16);
    push_idle(1, 1'b1);
    push_run();
    stop_at = sb.size();
    push_done(1);
    push_idle(2, 1'b0);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 15) Reset = 1'b1;
      if (c == 16) Reset = 1'b0;
      if (c == stop_at) Start = 1'b0;
      @(negedge Clk);
      e = sb.pop_front();
      a = observe(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_mid_run idx %0d: got %h want %h", c, a, e);
      end
      @(posedge Clk); #1;
      c++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, a;
    int   c;
    int   stop_at;
    Start = 1'b1;
    @(posedge Clk); #1;
    push_run();
    keep_first(9);
    push_idle(1, 1'b0);
    push_run();
    stop_at = sb.size();
    push_done(1);
    push_idle(2, 1'b0);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 8) Start = 1'b0;
      if (c == 9) Start = 1'b1;
      if (c == stop_at) Start = 1'b0;
      @(negedge Clk);
      e = sb.pop_front();
      a = observe(e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL back_to_back idx %0d: got %h want %h", c, a, e);
      end
      @(posedge Clk); #1;
      c++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset  = 1'b1;
    Start  = 1'b0;
    test_reset();
    test_full_run();
    test_done_hold();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/nn_sequencer.md
# nn_sequencer

Control FSM that runs one inference of the two-layer fully connected MNIST network on the shared MAC datapath. It starts when software sets the Start bit in the control register file and raises Done when the final output neuron has been written back. Done and Busy are read back through that register file. The block issues activation and weight addresses plus MAC and write-back strobes; it holds no arithmetic of its own.

## Interface
Parameters:
- N_IN, 784: layer-1 input count (pixels).
- N_HID, 64: hidden neurons; also the layer-2 input count.
- N_OUT, 10: output neurons.
- MAC_LAT, 2: cycles from the last Mac_En to a valid neuron result (memory plus MAC pipeline).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  level from the control register; its rising edge launches a run.
- Done  out  1  high from run completion until Start goes low.
- Busy  out  1  high while a run is in progress.
- Layer  out  1  0 = hidden layer, 1 = output layer.
- In_Addr  out  $clog2(N_IN)  activation read address (pixel RAM or hidden buffer, selected by Layer).
- W_Addr  out  $clog2(N_IN*N_HID+N_HID*N_OUT)  weight ROM address.
- Mac_En  out  1  In_Addr/W_Addr valid this cycle; accumulate the product.
- Mac_Clr  out  1  with Mac_En on a neuron's first element; the product loads the accumulator instead of adding to it.
- Neuron_WE  out  1  result valid; write it back (ReLU to the hidden buffer, raw to Probability).
- Neuron_Addr  out  $clog2(N_HID)  neuron index for Neuron_WE.

## Operation
- States are IDLE, MAC, DRAIN, WB, DONE.
- Counters:
  - elem counts 0..K-1, where K = N_IN for layer 0 and N_HID for layer 1.
  - neuron counts 0..M-1, where M = N_HID for layer 0 and N_OUT for layer 1.
  - drain counts 0..MAC_LAT-1.
  - wptr is the weight pointer.
- Start edge detect: start_q <= Start; rise = Start & ~start_q. start_q resets to 0.
- IDLE: on rise, go to MAC with Layer=0, elem=0, neuron=0, wptr=0. Otherwise stay in IDLE.
- MAC:
  - Outputs: Mac_En=1, In_Addr=elem, W_Addr=wptr, Mac_Clr=(elem==0).
  - Each cycle elem++ and wptr++.
  - At elem==K-1, go to DRAIN with elem=0.
- DRAIN: hold for MAC_LAT cycles with all strobes low, then go to WB.
- WB: Neuron_WE=1 for one cycle, Neuron_Addr=neuron. Then:
  - If neuron<M-1: neuron++, go to MAC.
  - Else if Layer==0: Layer=1, neuron=0, go to MAC.
  - Else go to DONE.
- Weight layout is row-major and contiguous, so wptr only increments; there are no multipliers. Layer-1 weights start at N_IN*N_HID.
- DONE: Done=1. When Start is low, go to IDLE and clear Done.
- Abort: Start low in MAC, DRAIN or WB sends the FSM to IDLE next cycle. No further Mac_En or Neuron_WE is issued and Done is not set.
- A rise while Busy or DONE is ignored. A new run needs Start to go 0 then 1.
- Busy = state is MAC, DRAIN or WB.
- Outputs are combinational decodes of registered state and counters only, with no Start-to-output path.

## Timing
- Reset: state=IDLE, all counters and start_q = 0. Done, Busy, Mac_En, Mac_Clr, Neuron_WE, Layer, In_Addr, W_Addr and Neuron_Addr are all 0.
- Reset mid-run aborts immediately; Reset has priority over every transition.
- Start held high through Reset release counts as a rise in the first cycle after Reset.
- Cycle 0 is the cycle after Start is first sampled high; it carries the first Mac_En, with Busy=1.
- Each neuron takes K+MAC_LAT+1 cycles.
- Total run length is T = N_HID*(N_IN+MAC_LAT+1) + N_OUT*(N_HID+MAC_LAT+1). Done rises in cycle T and Busy falls in the same cycle.
- Mac_En is never high in DRAIN, WB or DONE.
- Neuron_WE is never high in the same cycle as Mac_En.

## Structure
- Shared package nn_pkg holds:
  - the N_IN, N_HID and N_OUT constants;
  - the seq_state_t enum (IDLE, MAC, DRAIN, WB, DONE);
  - the derived W_BASE_L1 = N_IN*N_HID and address widths.
- The block is a single module. The FSM and the counters share the K and M selects, so no sub-module is needed.

## Test plan
Benches use N_IN=4, N_HID=3, N_OUT=2, MAC_LAT=2, which gives T=33.
- Reset then idle: all outputs 0 for 10 cycles with Start=0.
- Full run, Start 0->1: Mac_En runs in cycles 0-3 with W_Addr 0..3 and Mac_Clr only in cycle 0.
  - Neuron_WE fires in cycles 6, 13 and 20 with Addr 0, 1, 2.
  - Layer=1 from cycle 21. W_Addr runs 12..14, then 15..17.
  - Neuron_WE fires in cycles 26 and 32 with Addr 0 and 1.
  - Done=1 from cycle 33.
- Done hold and clear: Start kept high for 20 cycles after completion gives Done=1 throughout. Start low gives Done=0 next cycle. Start high again gives a new run with cycle 0 one cycle later.
- Abort: Start low in cycle 10 gives IDLE in cycle 11, with no Neuron_WE after cycle 6 and Done never set.
- Reset mid-run: Reset in cycle 15 clears all outputs next cycle. With Start still high after Reset, a run begins and its cycle 0 is 2 cycles after Reset drops.
- Second rise while Busy: Start pulsed 1-0-1 inside the run aborts on the 0. The next 1 is a clean rise that restarts the run from cycle 0.
